// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types and constants for the pipeline hazard controller: sequencer states,
// stall/flush vector codes ({SF,FF,SD,FD,SE,FE,SM,FM,SW,FW}) and forward selects.
package hazard_ctrl_mc_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [9:0] VEC_RESET   = 10'b0101010101;
  localparam logic [9:0] VEC_FREEZE  = 10'b1010101010;
  localparam logic [9:0] VEC_MD      = 10'b1010100100;
  localparam logic [9:0] VEC_MISPRED = 10'b0001010000;
  localparam logic [9:0] VEC_LDUSE   = 10'b1010010000;
  localparam logic [9:0] VEC_JALD    = 10'b0001000000;
  localparam logic [9:0] VEC_NONE    = 10'b0000000000;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // The younger producer in MEM always wins over the older one in WB.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Bundle between the datapath (master) and the hazard controller (slave).
interface hazard_ctrl_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);

  logic              ICacheMiss, DCacheMiss;
  logic              BranchE, PredTakenE, JalrE, JalD, MdStartE;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]        RegReadD, RegReadE;
  logic              MemToRegE, RegWriteM, RegWriteW, CntClr;

  logic              StallF, StallD, StallE, StallM, StallW;
  logic              FlushF, FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        Forward1E, Forward2E;
  logic              MdBusy, MdDone;
  logic [CNT_W-1:0]  StallCnt, MispredCnt, LdUseCnt;

  modport master (
    output ICacheMiss, DCacheMiss, BranchE, PredTakenE, JalrE, JalD, MdStartE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
           MemToRegE, RegWriteM, RegWriteW, CntClr,
    input  StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MdBusy, MdDone,
           StallCnt, MispredCnt, LdUseCnt
  );

  modport slave (
    input  ICacheMiss, DCacheMiss, BranchE, PredTakenE, JalrE, JalD, MdStartE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegReadD, RegReadE,
           MemToRegE, RegWriteM, RegWriteW, CntClr,
    output StallF, StallD, StallE, StallM, StallW,
           FlushF, FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, MdBusy, MdDone,
           StallCnt, MispredCnt, LdUseCnt
  );

endinterface

// File: rtl/hazard_ctrl_mc_md_seq.sv
// Mul/div sequencer: holds a multi-cycle op in EX for exactly MD_LAT stall cycles,
// then a one-cycle DONE in which EX advances. A pipeline freeze holds state and count.
module hazard_ctrl_mc_md_seq
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic freeze_i,
  input  logic start_i,
  output logic md_stall_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = $clog2(MD_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MD_LAT - 2);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (!freeze_i) begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        MD_BUSY: begin
          if (cnt_q == '0) state_q <= MD_DONE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // The IDLE start cycle already stalls, so BUSY only needs MD_LAT-1 cycles.
  assign md_stall_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_BUSY);
  assign busy_o     = (state_q != MD_IDLE);
  assign done_o     = (state_q == MD_DONE);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: priority stall/flush mux, EX forwarding selects,
// mul/div sequencing and saturating performance counters.
module hazard_ctrl_mc
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RST_N,
  hazard_ctrl_mc_if.slave  bus
);

  localparam logic [REG_AW-1:0] X0 = '0;

  logic       miss, md_stall, redirect, load_use;
  logic       mispred_sel, lduse_sel;
  logic [9:0] vec;
  logic       m_hit1, w_hit1, m_hit2, w_hit2;

  logic [CNT_W-1:0] stall_cnt_q, mispred_cnt_q, lduse_cnt_q;

  hazard_ctrl_mc_md_seq #(.MD_LAT(MD_LAT)) u_md_seq (
    .clk_i      (CPU_CLK),
    .rst_ni     (CPU_RST_N),
    .freeze_i   (miss),
    .start_i    (bus.MdStartE),
    .md_stall_o (md_stall),
    .busy_o     (bus.MdBusy),
    .done_o     (bus.MdDone)
  );

  assign miss     = bus.ICacheMiss | bus.DCacheMiss;
  assign redirect = bus.JalrE | (bus.BranchE != bus.PredTakenE);
  assign load_use = bus.MemToRegE && (bus.RdE != X0) &&
                    (((bus.RdE == bus.Rs1D) && bus.RegReadD[1]) ||
                     ((bus.RdE == bus.Rs2D) && bus.RegReadD[0]));

  // Only the winning rule drives the vector and the event counters.
  always_comb begin
    vec         = VEC_NONE;
    mispred_sel = 1'b0;
    lduse_sel   = 1'b0;
    if (!CPU_RST_N)     vec = VEC_RESET;
    else if (miss)      vec = VEC_FREEZE;
    else if (md_stall)  vec = VEC_MD;
    else if (redirect) begin
      vec         = VEC_MISPRED;
      mispred_sel = 1'b1;
    end else if (load_use) begin
      vec       = VEC_LDUSE;
      lduse_sel = 1'b1;
    end else if (bus.JalD) vec = VEC_JALD;
  end

  assign {bus.StallF, bus.FlushF, bus.StallD, bus.FlushD, bus.StallE,
          bus.FlushE, bus.StallM, bus.FlushM, bus.StallW, bus.FlushW} = vec;

  assign m_hit1 = bus.RegWriteM && (bus.RdM != X0) && (bus.RdM == bus.Rs1E) && bus.RegReadE[1];
  assign w_hit1 = bus.RegWriteW && (bus.RdW != X0) && (bus.RdW == bus.Rs1E) && bus.RegReadE[1];
  assign m_hit2 = bus.RegWriteM && (bus.RdM != X0) && (bus.RdM == bus.Rs2E) && bus.RegReadE[0];
  assign w_hit2 = bus.RegWriteW && (bus.RdW != X0) && (bus.RdW == bus.Rs2E) && bus.RegReadE[0];

  assign bus.Forward1E = CPU_RST_N ? fwd_sel(m_hit1, w_hit1) : FWD_RF;
  assign bus.Forward2E = CPU_RST_N ? fwd_sel(m_hit2, w_hit2) : FWD_RF;

  function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) stall_cnt_q <= '0;
    else            stall_cnt_q <= sat_next(stall_cnt_q, bus.StallF, bus.CntClr);
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) mispred_cnt_q <= '0;
    else            mispred_cnt_q <= sat_next(mispred_cnt_q, mispred_sel, bus.CntClr);
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) lduse_cnt_q <= '0;
    else            lduse_cnt_q <= sat_next(lduse_cnt_q, lduse_sel, bus.CntClr);
  end

  assign bus.StallCnt   = stall_cnt_q;
  assign bus.MispredCnt = mispred_cnt_q;
  assign bus.LdUseCnt   = lduse_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed-vector bench for hazard_ctrl_mc (MD_LAT=4, 4-bit counters so saturation is reachable).
module tb_hazard_ctrl_mc;

  localparam logic [9:0] V_RESET   = 10'b0101010101;
  localparam logic [9:0] V_FREEZE  = 10'b1010101010;
  localparam logic [9:0] V_MD      = 10'b1010100100;
  localparam logic [9:0] V_MISPRED = 10'b0001010000;
  localparam logic [9:0] V_LDUSE   = 10'b1010010000;
  localparam logic [9:0] V_JALD    = 10'b0001000000;
  localparam logic [9:0] V_NONE    = 10'b0000000000;

  logic clock = 1'b0;
  logic resetN;
  int   nVec  = 0;
  int   nFail = 0;

  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4)) hif ();

  hazard_ctrl_mc #(.REG_AW(5), .MD_LAT(4), .CNT_W(4)) dut (
    .CPU_CLK   (clock),
    .CPU_RST_N (resetN),
    .bus       (hif)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] getVec();
    return {hif.StallF, hif.FlushF, hif.StallD, hif.FlushD, hif.StallE,
            hif.FlushE, hif.StallM, hif.FlushM, hif.StallW, hif.FlushW};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    hif.ICacheMiss = 0; hif.DCacheMiss = 0; hif.BranchE = 0; hif.PredTakenE = 0;
    hif.JalrE = 0; hif.JalD = 0; hif.MdStartE = 0; hif.MemToRegE = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.CntClr = 0;
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0; hif.RegReadD = 0; hif.RegReadE = 0;
  endtask

  task automatic clearCounters();
    hif.CntClr = 1;
    tick();
    hif.CntClr = 0;
    #1;
  endtask

  task automatic test_reset();
    resetN = 0;
    idleInputs();
    hif.RegWriteM = 1; hif.RdM = 3; hif.Rs1E = 3; hif.RegReadE = 2'b10;
    #2;
    nVec++;
    if (getVec() !== V_RESET) begin nFail++; $display("[TB] FAIL reset_vec: got %b expected %b", getVec(), V_RESET); end
    nVec++;
    if (hif.Forward1E !== 2'b00) begin nFail++; $display("[TB] FAIL reset_fwd1: got %b expected 00", hif.Forward1E); end
    nVec++;
    if ({hif.MdBusy, hif.MdDone} !== 2'b00) begin nFail++; $display("[TB] FAIL reset_md: got %b expected 00", {hif.MdBusy, hif.MdDone}); end
    nVec++;
    if ({hif.StallCnt, hif.MispredCnt, hif.LdUseCnt} !== 12'h000) begin nFail++; $display("[TB] FAIL reset_cnt: got %h expected 000", {hif.StallCnt, hif.MispredCnt, hif.LdUseCnt}); end
    tick();
    tick();
    resetN = 1;
    idleInputs();
    #1;
    nVec++;
    if (getVec() !== V_NONE) begin nFail++; $display("[TB] FAIL post_reset_vec: got %b expected %b", getVec(), V_NONE); end
  endtask

  task automatic test_muldiv();
    clearCounters();
    hif.MdStartE = 1;
    #1;
    nVec++;
    if (getVec() !== V_MD || hif.MdBusy !== 1'b0) begin nFail++; $display("[TB] FAIL md_start: got %b/%b expected %b/0", getVec(), hif.MdBusy, V_MD); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nVec++;
      if (getVec() !== V_MD || hif.MdBusy !== 1'b1 || hif.MdDone !== 1'b0) begin
        nFail++; $display("[TB] FAIL md_busy%0d: got %b/%b%b expected %b/10", i, getVec(), hif.MdBusy, hif.MdDone, V_MD);
      end
    end
    tick();
    nVec++;
    if (getVec() !== V_NONE || hif.MdDone !== 1'b1) begin nFail++; $display("[TB] FAIL md_done: got %b/%b expected %b/1", getVec(), hif.MdDone, V_NONE); end
    hif.MdStartE = 0;
    tick();
    nVec++;
    if ({hif.MdBusy, hif.MdDone} !== 2'b00) begin nFail++; $display("[TB] FAIL md_idle: got %b expected 00", {hif.MdBusy, hif.MdDone}); end
    nVec++;
    if (hif.StallCnt !== 4'd4) begin nFail++; $display("[TB] FAIL md_stallcnt: got %0d expected 4", hif.StallCnt); end
  endtask

  task automatic test_freeze_md();
    clearCounters();
    hif.MdStartE = 1;
    tick();
    tick();
    hif.DCacheMiss = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      nVec++;
      if (getVec() !== V_FREEZE || hif.MdBusy !== 1'b1) begin nFail++; $display("[TB] FAIL freeze%0d: got %b/%b expected %b/1", i, getVec(), hif.MdBusy, V_FREEZE); end
      tick();
    end
    hif.DCacheMiss = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      nVec++;
      if (getVec() !== V_MD || hif.MdDone !== 1'b0) begin nFail++; $display("[TB] FAIL freeze_resume%0d: got %b/%b expected %b/0", i, getVec(), hif.MdDone, V_MD); end
      tick();
    end
    nVec++;
    if (hif.MdDone !== 1'b1) begin nFail++; $display("[TB] FAIL freeze_late_done: got %b expected 1", hif.MdDone); end
    hif.DCacheMiss = 1;
    tick();
    nVec++;
    if (hif.MdDone !== 1'b1 || getVec() !== V_FREEZE) begin nFail++; $display("[TB] FAIL freeze_in_done: got %b/%b expected 1/%b", hif.MdDone, getVec(), V_FREEZE); end
    hif.DCacheMiss = 0;
    hif.MdStartE = 0;
    tick();
    nVec++;
    if (hif.MdBusy !== 1'b0 || hif.StallCnt !== 4'd8) begin nFail++; $display("[TB] FAIL freeze_end: busy %b cnt %0d expected 0/8", hif.MdBusy, hif.StallCnt); end
  endtask

  task automatic test_mispred_priority();
    clearCounters();
    hif.MemToRegE = 1; hif.RdE = 5; hif.Rs1D = 5; hif.RegReadD = 2'b10;
    hif.BranchE = 0; hif.PredTakenE = 1;
    #1;
    nVec++;
    if (getVec() !== V_MISPRED) begin nFail++; $display("[TB] FAIL mispred_vec: got %b expected %b", getVec(), V_MISPRED); end
    tick();
    idleInputs();
    #1;
    nVec++;
    if ({hif.StallCnt, hif.MispredCnt, hif.LdUseCnt} !== {4'd0, 4'd1, 4'd0}) begin
      nFail++; $display("[TB] FAIL mispred_cnt: got %h expected 010", {hif.StallCnt, hif.MispredCnt, hif.LdUseCnt});
    end
    hif.JalrE = 1;
    #1;
    nVec++;
    if (getVec() !== V_MISPRED) begin nFail++; $display("[TB] FAIL jalr_vec: got %b expected %b", getVec(), V_MISPRED); end
    idleInputs();
  endtask

  task automatic test_load_use();
    clearCounters();
    hif.MemToRegE = 1; hif.RdE = 0; hif.Rs1D = 0; hif.RegReadD = 2'b10;
    #1;
    nVec++;
    if (getVec() !== V_NONE) begin nFail++; $display("[TB] FAIL lduse_x0: got %b expected %b", getVec(), V_NONE); end
    hif.RdE = 5; hif.Rs2D = 5; hif.RegReadD = 2'b10;
    #1;
    nVec++;
    if (getVec() !== V_NONE) begin nFail++; $display("[TB] FAIL lduse_noread: got %b expected %b", getVec(), V_NONE); end
    hif.RegReadD = 2'b01;
    #1;
    nVec++;
    if (getVec() !== V_LDUSE) begin nFail++; $display("[TB] FAIL lduse_vec: got %b expected %b", getVec(), V_LDUSE); end
    tick();
    idleInputs();
    hif.JalD = 1;
    #1;
    nVec++;
    if (getVec() !== V_JALD) begin nFail++; $display("[TB] FAIL jald_vec: got %b expected %b", getVec(), V_JALD); end
    nVec++;
    if (hif.LdUseCnt !== 4'd1 || hif.StallCnt !== 4'd1) begin nFail++; $display("[TB] FAIL lduse_cnt: ld %0d stall %0d expected 1/1", hif.LdUseCnt, hif.StallCnt); end
    idleInputs();
  endtask

  task automatic test_forwarding();
    hif.RdM = 7; hif.RdW = 7; hif.Rs1E = 7; hif.RegWriteM = 1; hif.RegWriteW = 1; hif.RegReadE = 2'b10;
    #1;
    nVec++;
    if (hif.Forward1E !== 2'b10 || hif.Forward2E !== 2'b00) begin nFail++; $display("[TB] FAIL fwd_mem: got %b/%b expected 10/00", hif.Forward1E, hif.Forward2E); end
    hif.RdM = 0;
    #1;
    nVec++;
    if (hif.Forward1E !== 2'b01) begin nFail++; $display("[TB] FAIL fwd_wb: got %b expected 01", hif.Forward1E); end
    hif.RegReadE = 2'b00;
    #1;
    nVec++;
    if (hif.Forward1E !== 2'b00) begin nFail++; $display("[TB] FAIL fwd_noread: got %b expected 00", hif.Forward1E); end
    hif.Rs2E = 9; hif.RdW = 9; hif.RdM = 9; hif.RegWriteM = 0; hif.RegReadE = 2'b01;
    #1;
    nVec++;
    if (hif.Forward2E !== 2'b01 || hif.Forward1E !== 2'b00) begin nFail++; $display("[TB] FAIL fwd2_wb: got %b/%b expected 00/01", hif.Forward1E, hif.Forward2E); end
    idleInputs();
  endtask

  task automatic test_saturation();
    clearCounters();
    hif.DCacheMiss = 1;
    for (int i = 0; i < 20; i++) tick();
    hif.DCacheMiss = 0;
    #1;
    nVec++;
    if (hif.StallCnt !== 4'hF) begin nFail++; $display("[TB] FAIL sat_stall: got %h expected f", hif.StallCnt); end
    nVec++;
    if (hif.MispredCnt !== 4'd0) begin nFail++; $display("[TB] FAIL sat_freeze_hold: got %0d expected 0", hif.MispredCnt); end
    hif.DCacheMiss = 1;
    hif.CntClr = 1;
    tick();
    hif.DCacheMiss = 0;
    hif.CntClr = 0;
    #1;
    nVec++;
    if (hif.StallCnt !== 4'd0) begin nFail++; $display("[TB] FAIL clr_beats_inc: got %0d expected 0", hif.StallCnt); end
  endtask

  task automatic test_reset_mid_busy();
    hif.MdStartE = 1;
    tick();
    tick();
    nVec++;
    if (hif.MdBusy !== 1'b1 || hif.StallCnt !== 4'd2) begin nFail++; $display("[TB] FAIL prereset_busy: busy %b cnt %0d expected 1/2", hif.MdBusy, hif.StallCnt); end
    resetN = 0;
    #1;
    nVec++;
    if (hif.MdBusy !== 1'b0 || getVec() !== V_RESET || hif.StallCnt !== 4'd0) begin
      nFail++; $display("[TB] FAIL midbusy_reset: busy %b vec %b cnt %0d expected 0/%b/0", hif.MdBusy, getVec(), hif.StallCnt, V_RESET);
    end
    hif.MdStartE = 0;
    tick();
    resetN = 1;
    tick();
    nVec++;
    if (hif.MdBusy !== 1'b0 || getVec() !== V_NONE) begin nFail++; $display("[TB] FAIL after_reset: busy %b vec %b expected 0/%b", hif.MdBusy, getVec(), V_NONE); end
  endtask

  initial begin
    test_reset();
    test_muldiv();
    test_freeze_md();
    test_mispred_priority();
    test_load_use();
    test_forwarding();
    test_saturation();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
